seq_detector_param: RTL and testbench
=====================================

// Module: seq_detector_param
// PURPOSE
//  Serial bit-pattern detector with pattern width and value set by parameters; successor to the fixed 4-bit
//  Moore detectors. Pattern reloadable at runtime; overlap / non-overlap selected per cycle. Optional
//  saturating detection counter. Sits after serial sampling logic, one bit per valid cycle, MSB of pattern first.
// PARAMETERS
//  PAT_W    4        pattern length in bits, legal 2..16
//  PATTERN  4'b1011  reset/default pattern, PAT_W bits; PATTERN[PAT_W-1] is the first bit received
//  CNT_W    8        detection counter width, legal 1..32
// PORTS
//  clk             in   1      clock, all logic on posedge
//  rst             in   1      synchronous, active-high reset
//  d_in            in   1      serial data bit
//  d_valid         in   1      d_in sampled only when high; state holds when low
//  overlap_en      in   1      1 = overlapping matches, 0 = non-overlapping; sampled every cycle
//  pat_ld          in   1      load pat_in as new pattern
//  pat_in          in   PAT_W  new pattern value
//  pattern_detect  out  1      one-cycle registered pulse per complete match
//  match_len       out  $clog2(PAT_W+1)  current matched-prefix length (state), for debug
//  detect_count    out  CNT_W  saturating count of matches
//  count_sat       out  1      high when detect_count is all ones
// BEHAVIOUR
//  - Reset: pat_reg=PATTERN, match_len=0, pattern_detect=0, detect_count=0, count_sat=0.
//  - State = match length L in 0..PAT_W: the last L accepted bits equal the first L pattern bits.
//  - On d_valid: base B = L, except B=0 when L==PAT_W and overlap_en==0. Next L = largest k <= min(B+1,PAT_W)
//    such that the last k bits of {prefix(B), d_in} equal prefix(k). This is a KMP-style fallback, so no
//    match is lost on mismatch.
//  - pattern_detect=1 exactly in the cycle after the edge at which next L==PAT_W. Otherwise 0, including while
//    L stays PAT_W with d_valid low. Back-to-back pulses are legal in overlap mode.
//  - Latency: last pattern bit sampled at edge N -> pattern_detect high N..N+1.
//  - pat_ld=1: pat_reg<=pat_in, L<=0, pattern_detect<=0, d_in ignored that cycle. detect_count is kept.
//    pat_ld has priority over d_valid.
//  - overlap_en affects only the transition out of L==PAT_W. Changing it mid-match has no other effect.
//  - rst has priority over everything. rst mid-match discards the partial match.
//  - Counter: +1 on each pattern_detect pulse. It holds at 2^CNT_W-1 with no wrap. count_sat is combinational
//    from detect_count.
// CONFIGURATION
//  - SEQDET_COUNT_EN defined: counter and count_sat are implemented as above.
//  - SEQDET_COUNT_EN undefined: no counter flops; detect_count tied 0, count_sat tied 0. Ports stay present.
// STRUCTURE
//  - Package seq_det_pkg: PAT_W_MIN/PAT_W_MAX, CNT_W_MAX limits, default pattern constant, and
//    function next_match_len(pat, len, bit, pat_w) used by RTL and the bench model.
//  - Sub-module seq_det_match: combinational next-L calculator (pattern, L, d_in, overlap_en -> next L).
//  - Top holds pat_reg, L register, detect pulse flop and the optional counter.
//  - Elaboration check: PAT_W and CNT_W inside legal ranges.
// TESTING
//  1. PATTERN=1011, overlap_en=1, bits 1011011 valid every cycle -> pulses after bits 4 and 7, count=2.
//  2. Same stream, overlap_en=0 -> single pulse after bit 4, count=1, match_len=1 after bit 7.
//  3. pat_ld with pat_in=1111, then 7 ones: overlap -> 4 pulses (after bits 4..7); non-overlap -> 1 pulse.
//  4. PATTERN=1011, bits 1,0,1,1 with d_valid low 2 cycles between each -> one pulse, 1 cycle wide.
//     match_len=4 held until next valid bit.
//  5. Bits 1,0,1, then rst one cycle, then 1 -> no pulse, match_len=1, count=0. Repeat with pat_ld
//     instead of rst -> same result.
//  6. CNT_W=2, SEQDET_COUNT_EN defined, 5 matches -> count=3, count_sat=1. Macro undefined -> count=0, count_sat=0.

Source files
------------

// File: rtl/seq_det_pkg.sv
// -----------------------------------------------------------------------------
// seq_det_pkg
// Shared limits, default pattern and the match-length step function for the
// parameterised serial pattern detector.
//   PAT_W_MIN / PAT_W_MAX : legal pattern widths
//   CNT_W_MAX             : widest legal detection counter
//   DEFAULT_PATTERN       : reset pattern (1011), right-aligned
//   next_match_len()      : longest pattern prefix that is a suffix of
//                           {prefix(base), bit_in}
// -----------------------------------------------------------------------------
package seq_det_pkg;

  localparam int PAT_W_MIN = 2;
  localparam int PAT_W_MAX = 16;
  localparam int CNT_W_MAX = 32;
  localparam int LEN_W_MAX = 5;  // holds 0..PAT_W_MAX

  typedef logic [PAT_W_MAX-1:0] pat_t;
  typedef logic [LEN_W_MAX-1:0] len_t;

  localparam pat_t DEFAULT_PATTERN = 16'b1011;

  // pat is right-aligned with zeros above pat_w; pat[pat_w-1] is the first
  // bit received, so prefix(k) is the top k bits of the pattern.
  // Returns the largest k <= min(base+1, pat_w) whose prefix(k) equals the
  // last k bits of {prefix(base), bit_in}.
  function automatic len_t next_match_len(input pat_t pat, input len_t base,
                                          input logic bit_in, input len_t pat_w);
    logic [31:0] pfx_b;
    logic [31:0] s;
    logic [31:0] pfx_k;
    logic [31:0] mask;
    len_t        res;
    int          lim;
    res   = '0;
    // Upper pattern bits are zero, so a shift by pat_w yields prefix(0) = 0.
    pfx_b = 32'(pat) >> (pat_w - base);
    s     = (pfx_b << 1) | {31'b0, bit_in};
    lim   = (int'(base) + 1 < int'(pat_w)) ? int'(base) + 1 : int'(pat_w);
    for (int k = 1; k <= PAT_W_MAX; k++) begin
      if (k <= lim) begin
        mask  = (32'd1 << k) - 32'd1;
        pfx_k = 32'(pat) >> (int'(pat_w) - k);
        if ((s & mask) == (pfx_k & mask)) res = len_t'(k);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/seq_det_match.sv
// -----------------------------------------------------------------------------
// seq_det_match
// Combinational next-state calculator for the detector: given the current
// pattern, matched length and incoming bit, produce the next matched length.
//   pat_i        : current pattern, PAT_W bits, MSB received first
//   len_i        : current matched-prefix length (0..PAT_W)
//   d_i          : incoming serial bit
//   overlap_en_i : 1 keeps a full match as the fallback base, 0 restarts
//   len_o        : next matched-prefix length
// -----------------------------------------------------------------------------
module seq_det_match
  import seq_det_pkg::*;
#(
  parameter int PAT_W = 4
) (
  input  logic [PAT_W-1:0]             pat_i,
  input  logic [$clog2(PAT_W+1)-1:0]   len_i,
  input  logic                         d_i,
  input  logic                         overlap_en_i,
  output logic [$clog2(PAT_W+1)-1:0]   len_o
);

  localparam int LEN_W = $clog2(PAT_W+1);

  logic [LEN_W-1:0] base;
  len_t             nxt;

  // In non-overlap mode a completed match is discarded before the new bit.
  always_comb begin
    base = len_i;
    if ((len_i == LEN_W'(PAT_W)) && !overlap_en_i) base = '0;
  end

  assign nxt   = next_match_len(pat_t'(pat_i), len_t'(base), d_i, len_t'(PAT_W));
  assign len_o = LEN_W'(nxt);

endmodule

// File: rtl/seq_detector_param.sv
// -----------------------------------------------------------------------------
// seq_detector_param
// Serial bit-pattern detector with runtime-loadable pattern, per-cycle
// overlap selection and an optional saturating match counter.
// Optional feature macro: SEQDET_COUNT_EN (counter + count_sat implemented;
// when undefined both outputs are tied to zero).
// Ports:
//   clk            : clock, posedge
//   rst            : synchronous active-high reset
//   d_in, d_valid  : serial bit and its qualifier
//   overlap_en     : 1 = overlapping matches, 0 = non-overlapping
//   pat_ld, pat_in : load a new pattern (clears the partial match)
//   pattern_detect : one-cycle registered pulse per full match
//   match_len      : current matched-prefix length
//   detect_count   : saturating match count
//   count_sat      : detect_count is all ones
// -----------------------------------------------------------------------------
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEFAULT_PATTERN),
  parameter int               CNT_W   = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        d_in,
  input  logic                        d_valid,
  input  logic                        overlap_en,
  input  logic                        pat_ld,
  input  logic [PAT_W-1:0]            pat_in,
  output logic                        pattern_detect,
  output logic [$clog2(PAT_W+1)-1:0]  match_len,
  output logic [CNT_W-1:0]            detect_count,
  output logic                        count_sat
);

  localparam int LEN_W = $clog2(PAT_W+1);

  if (PAT_W < PAT_W_MIN || PAT_W > PAT_W_MAX) begin : g_bad_pat_w
    $error("seq_detector_param: PAT_W out of range");
  end
  if (CNT_W < 1 || CNT_W > CNT_W_MAX) begin : g_bad_cnt_w
    $error("seq_detector_param: CNT_W out of range");
  end

  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d, len_nxt;
  logic             det_q, det_d;

  seq_det_match #(.PAT_W(PAT_W)) u_match (
    .pat_i        (pat_q),
    .len_i        (len_q),
    .d_i          (d_in),
    .overlap_en_i (overlap_en),
    .len_o        (len_nxt)
  );

  // Pattern load wins over data; the detect pulse only fires on the edge
  // that completes a match, never while a full match is merely held.
  always_comb begin
    pat_d = pat_q;
    len_d = len_q;
    det_d = 1'b0;
    if (pat_ld) begin
      pat_d = pat_in;
      len_d = '0;
    end else if (d_valid) begin
      len_d = len_nxt;
      det_d = (len_nxt == LEN_W'(PAT_W));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q <= PATTERN;
      len_q <= '0;
      det_q <= 1'b0;
    end else begin
      pat_q <= pat_d;
      len_q <= len_d;
      det_q <= det_d;
    end
  end

  assign pattern_detect = det_q;
  assign match_len      = len_q;

`ifdef SEQDET_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counts the registered pulse, so the count follows it by one cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (det_q && !(&cnt_q)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign detect_count = cnt_q;
  assign count_sat    = &cnt_q;
`else
  assign detect_count = '0;
  assign count_sat    = 1'b0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
module tb_seq_detector_param;

  localparam int PAT_W = 4;
  localparam int LEN_W = $clog2(PAT_W+1);
`ifdef SEQDET_COUNT_EN
  localparam int CNT_ON = 1;
`else
  localparam int CNT_ON = 0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             d_in = 1'b0;
  logic             d_valid = 1'b0;
  logic             overlap_en = 1'b1;
  logic             pat_ld = 1'b0;
  logic [PAT_W-1:0] pat_in = '0;

  logic             pattern_detect;
  logic [LEN_W-1:0] match_len;
  logic [7:0]       detect_count;
  logic             count_sat;

  logic             pd2;
  logic [LEN_W-1:0] ml2;
  logic [1:0]       dc2;
  logic             cs2;

  int n_tests = 0;
  int n_fail  = 0;

  seq_detector_param #(.PAT_W(PAT_W), .PATTERN(4'b1011), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .d_in(d_in), .d_valid(d_valid),
    .overlap_en(overlap_en), .pat_ld(pat_ld), .pat_in(pat_in),
    .pattern_detect(pattern_detect), .match_len(match_len),
    .detect_count(detect_count), .count_sat(count_sat)
  );

  seq_detector_param #(.PAT_W(PAT_W), .PATTERN(4'b1011), .CNT_W(2)) dut_c2 (
    .clk(clk), .rst(rst), .d_in(d_in), .d_valid(d_valid),
    .overlap_en(overlap_en), .pat_ld(pat_ld), .pat_in(pat_in),
    .pattern_detect(pd2), .match_len(ml2),
    .detect_count(dc2), .count_sat(cs2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic b, input logic v);
    d_in    = b;
    d_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    d_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    d_valid = 1'b0;
    pat_ld  = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic load_pat(input logic [PAT_W-1:0] p);
    pat_ld  = 1'b1;
    pat_in  = p;
    d_in    = 1'b1;
    d_valid = 1'b1;
    @(posedge clk);
    #1;
    pat_ld  = 1'b0;
    d_valid = 1'b0;
  endtask

  // Sends n valid bits MSB first, collecting pattern_detect after each edge.
  task automatic send_bits(input logic [15:0] bits, input int n, output logic [15:0] dv);
    dv = '0;
    for (int i = n - 1; i >= 0; i--) begin
      step(bits[i], 1'b1);
      dv = {dv[14:0], pattern_detect};
    end
    d_valid = 1'b0;
  endtask

  logic [15:0] dv;
  logic [15:0] bits4;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_detect", 32'(pattern_detect), 32'd0);
    check("reset_len",    32'(match_len),      32'd0);
    check("reset_count",  32'(detect_count),   32'd0);
    check("reset_sat",    32'(count_sat),      32'd0);
    rst = 1'b0;

    // 1: overlapping detection of 1011011
    overlap_en = 1'b1;
    send_bits(16'b1011011, 7, dv);
    check("t1_pulses", 32'(dv[6:0]), 32'b0001001);
    check("t1_len",    32'(match_len), 32'd4);
    idle(1);
    check("t1_count",  32'(detect_count), 32'(2 * CNT_ON));
    check("t1_hold_len", 32'(match_len), 32'd4);
    check("t1_hold_det", 32'(pattern_detect), 32'd0);

    // 2: same stream, non-overlapping
    do_reset();
    overlap_en = 1'b0;
    send_bits(16'b1011011, 7, dv);
    check("t2_pulses", 32'(dv[6:0]), 32'b0001000);
    check("t2_len",    32'(match_len), 32'd1);
    idle(1);
    check("t2_count",  32'(detect_count), 32'(CNT_ON));

    // 3: reloaded pattern 1111, overlap then non-overlap
    do_reset();
    load_pat(4'b1111);
    check("t3_ld_len", 32'(match_len), 32'd0);
    check("t3_ld_det", 32'(pattern_detect), 32'd0);
    overlap_en = 1'b1;
    send_bits(16'b1111111, 7, dv);
    check("t3_ov_pulses", 32'(dv[6:0]), 32'b0001111);
    idle(1);
    check("t3_ov_count", 32'(detect_count), 32'(4 * CNT_ON));
    load_pat(4'b1111);
    check("t3_ld2_len", 32'(match_len), 32'd0);
    check("t3_kept_count", 32'(detect_count), 32'(4 * CNT_ON));
    overlap_en = 1'b0;
    send_bits(16'b1111111, 7, dv);
    check("t3_no_pulses", 32'(dv[6:0]), 32'b0001000);
    check("t3_no_len", 32'(match_len), 32'd3);
    idle(1);
    check("t3_no_count", 32'(detect_count), 32'(5 * CNT_ON));

    // 4: gaps of two invalid cycles between bits of 1011
    do_reset();
    overlap_en = 1'b1;
    bits4 = 16'b1011;
    dv = '0;
    for (int i = 3; i >= 0; i--) begin
      step(bits4[i], 1'b1);
      dv = {dv[14:0], pattern_detect};
      for (int j = 0; j < 2; j++) begin
        step(~bits4[i], 1'b0);
        dv = {dv[14:0], pattern_detect};
      end
    end
    check("t4_pulse_shape", 32'(dv[11:0]), 32'b0000_0000_0100);
    check("t4_len_held", 32'(match_len), 32'd4);
    step(1'b0, 1'b1);
    check("t4_after_len", 32'(match_len), 32'd2);

    // 5: reset mid-match discards partial match
    do_reset();
    send_bits(16'b101, 3, dv);
    check("t5_partial_len", 32'(match_len), 32'd3);
    do_reset();
    check("t5_rst_len", 32'(match_len), 32'd0);
    send_bits(16'b1, 1, dv);
    check("t5_rst_det", 32'(dv[0]), 32'd0);
    check("t5_rst_len2", 32'(match_len), 32'd1);
    idle(1);
    check("t5_rst_count", 32'(detect_count), 32'd0);
    // pattern load mid-match behaves the same
    send_bits(16'b01, 2, dv);
    check("t5b_partial_len", 32'(match_len), 32'd3);
    load_pat(4'b1011);
    check("t5b_ld_len", 32'(match_len), 32'd0);
    send_bits(16'b1, 1, dv);
    check("t5b_ld_det", 32'(dv[0]), 32'd0);
    check("t5b_ld_len2", 32'(match_len), 32'd1);
    idle(1);
    check("t5b_ld_count", 32'(detect_count), 32'd0);

    // 6: five matches, 2-bit counter saturates
    do_reset();
    overlap_en = 1'b1;
    send_bits(16'b1011_1011, 8, dv);
    check("t6_pulses_a", 32'(dv[7:0]), 32'b0001_0001);
    idle(1);
    check("t6_c2_mid_count", 32'(dc2), 32'(2 * CNT_ON));
    check("t6_c2_mid_sat",   32'(cs2), 32'd0);
    send_bits(16'b1011_1011_1011, 12, dv);
    check("t6_pulses_b", 32'(dv[11:0]), 32'b0001_0001_0001);
    idle(2);
    check("t6_count",     32'(detect_count), 32'(5 * CNT_ON));
    check("t6_sat",       32'(count_sat),    32'd0);
    check("t6_c2_count",  32'(dc2),          32'(3 * CNT_ON));
    check("t6_c2_sat",    32'(cs2),          32'(CNT_ON));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
